// File: rtl/ltl_symbol_feeder.sv
// Buffers tracer symbols and feeds one automaton instance. Each trace is framed with a
// one-cycle automaton reset, and the first report hit of the trace is latched.
module ltl_symbol_feeder #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned NUM_REPORTS = 4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   sym_valid_i,
    output logic                   sym_ready_o,
    input  logic [7:0]             sym_data_i,
    input  logic                   sym_sof_i,
    input  logic                   abort_i,
    output logic                   am_reset_o,
    output logic                   am_run_o,
    output logic [7:0]             am_symbols_o,
    input  logic [NUM_REPORTS-1:0] report_i,
    output logic                   report_hit_o,
    output logic [CNT_W-1:0]       first_hit_idx_o,
    output logic [CNT_W-1:0]       sym_count_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [0:0] {StRun, StStart} state_e;

    logic [8:0]       mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic             full, empty, push, pop, clear;
    logic [8:0]       head;
    state_e           state_q, state_d;
    logic             am_reset_q, am_reset_d, am_run_q, am_run_d;
    logic [7:0]       am_symbols_q, am_symbols_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] idx_q, idx_d, count_q, count_d;

    // Extra pointer bit tells full (MSBs differ) from empty (pointers equal).
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign push  = sym_valid_i && !full && !abort_i;

    assign sym_ready_o     = !full;
    assign am_reset_o      = am_reset_q;
    assign am_run_o        = am_run_q;
    assign am_symbols_o    = am_symbols_q;
    assign report_hit_o    = hit_q;
    assign first_hit_idx_o = idx_q;
    assign sym_count_o     = count_q;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        clear        = 1'b0;
        am_reset_d   = am_reset_q;
        am_run_d     = 1'b0;
        am_symbols_d = am_symbols_q;
        count_d      = count_q;
        if (abort_i) begin
            am_reset_d = 1'b0;
            state_d    = StRun;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (empty) begin
                        am_reset_d = 1'b0;
                    end else if (!head[8]) begin
                        pop          = 1'b1;
                        am_symbols_d = head[7:0];
                        am_run_d     = 1'b1;
                        am_reset_d   = 1'b0;
                        if (count_q != {CNT_W{1'b1}}) begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        // Hold the sof symbol back one cycle so reset release and
                        // the first symbol land on the same edge.
                        am_reset_d = 1'b1;
                        clear      = 1'b1;
                        count_d    = '0;
                        state_d    = StStart;
                    end
                end
                StStart: begin
                    pop          = 1'b1;
                    am_reset_d   = 1'b0;
                    am_run_d     = 1'b1;
                    am_symbols_d = head[7:0];
                    count_d      = CNT_W'(1);
                    state_d      = StRun;
                end
                default: state_d = StRun;
            endcase
        end

        hit_d = hit_q;
        idx_d = idx_q;
        if (clear) begin
            hit_d = 1'b0;
            idx_d = '0;
        end else if (!am_reset_q && |report_i) begin
            hit_d = 1'b1;
            if (!hit_q) begin
                idx_d = count_q;
            end
        end

        wr_ptr_d = wr_ptr_q + (AW + 1)'(push);
        rd_ptr_d = rd_ptr_q + (AW + 1)'(pop);
        if (abort_i) begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = wr_ptr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StRun;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            am_reset_q   <= 1'b1;
            am_run_q     <= 1'b0;
            am_symbols_q <= '0;
            hit_q        <= 1'b0;
            idx_q        <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            am_reset_q   <= am_reset_d;
            am_run_q     <= am_run_d;
            am_symbols_q <= am_symbols_d;
            hit_q        <= hit_d;
            idx_q        <= idx_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {sym_sof_i, sym_data_i};
        end
    end

endmodule

// File: tb/tb_ltl_symbol_feeder.sv
// Self-checking bench for ltl_symbol_feeder: directed trace scenarios plus a randomized
// run scored against a queue-based model of the symbol stream and report latching.
module tb_ltl_symbol_feeder;
    localparam int unsigned DEPTH       = 4;
    localparam int unsigned NUM_REPORTS = 4;
    localparam int unsigned CNT_W       = 16;

    logic             clk = 1'b0;
    logic             rst_ni = 1'b0;
    logic             sym_valid = 1'b0;
    logic             sym_sof = 1'b0;
    logic [7:0]       sym_data = 8'h00;
    logic             abort = 1'b0;
    logic [3:0]       report = 4'h0;
    logic             sym_ready, am_reset, am_run, report_hit;
    logic [7:0]       am_symbols;
    logic [CNT_W-1:0] first_hit_idx, sym_count;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ltl_symbol_feeder #(
        .DEPTH      (DEPTH),
        .NUM_REPORTS(NUM_REPORTS),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .sym_valid_i    (sym_valid),
        .sym_ready_o    (sym_ready),
        .sym_data_i     (sym_data),
        .sym_sof_i      (sym_sof),
        .abort_i        (abort),
        .am_reset_o     (am_reset),
        .am_run_o       (am_run),
        .am_symbols_o   (am_symbols),
        .report_i       (report),
        .report_hit_o   (report_hit),
        .first_hit_idx_o(first_hit_idx),
        .sym_count_o    (sym_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        step();
        step();
        total += 7;
        if (am_reset !== 1'b1) begin bad++; $display("FAIL rst_am_reset got=%b want=1", am_reset); end
        if (am_run !== 1'b0) begin bad++; $display("FAIL rst_am_run got=%b want=0", am_run); end
        if (am_symbols !== 8'h00) begin bad++; $display("FAIL rst_symbols got=%h want=00", am_symbols); end
        if (report_hit !== 1'b0) begin bad++; $display("FAIL rst_hit got=%b want=0", report_hit); end
        if (first_hit_idx !== '0) begin bad++; $display("FAIL rst_idx got=%0d want=0", first_hit_idx); end
        if (sym_count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", sym_count); end
        if (sym_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b want=1", sym_ready); end
        rst_ni = 1'b1;
        step();
        total++;
        if (am_reset !== 1'b0) begin bad++; $display("FAIL poweron_reset_drop got=%b want=0", am_reset); end
        step();
    endtask

    task automatic test_framing();
        sym_valid = 1'b1; sym_sof = 1'b1; sym_data = 8'h05;
        step();
        total++;
        if (am_run !== 1'b0) begin bad++; $display("FAIL frm_idle_run got=%b want=0", am_run); end
        sym_sof = 1'b0; sym_data = 8'h88;
        step();
        total += 3;
        if (am_reset !== 1'b1) begin bad++; $display("FAIL frm_reset got=%b want=1", am_reset); end
        if (am_run !== 1'b0) begin bad++; $display("FAIL frm_reset_run got=%b want=0", am_run); end
        if (sym_count !== 16'd0) begin bad++; $display("FAIL frm_reset_count got=%0d want=0", sym_count); end
        sym_data = 8'h10;
        step();
        total += 4;
        if (am_reset !== 1'b0) begin bad++; $display("FAIL frm_s0_reset got=%b want=0", am_reset); end
        if (am_run !== 1'b1) begin bad++; $display("FAIL frm_s0_run got=%b want=1", am_run); end
        if (am_symbols !== 8'h05) begin bad++; $display("FAIL frm_s0_sym got=%h want=05", am_symbols); end
        if (sym_count !== 16'd1) begin bad++; $display("FAIL frm_s0_count got=%0d want=1", sym_count); end
        sym_valid = 1'b0;
        step();
        total += 3;
        if (am_run !== 1'b1) begin bad++; $display("FAIL frm_s1_run got=%b want=1", am_run); end
        if (am_symbols !== 8'h88) begin bad++; $display("FAIL frm_s1_sym got=%h want=88", am_symbols); end
        if (sym_count !== 16'd2) begin bad++; $display("FAIL frm_s1_count got=%0d want=2", sym_count); end
        step();
        total += 3;
        if (am_run !== 1'b1) begin bad++; $display("FAIL frm_s2_run got=%b want=1", am_run); end
        if (am_symbols !== 8'h10) begin bad++; $display("FAIL frm_s2_sym got=%h want=10", am_symbols); end
        if (sym_count !== 16'd3) begin bad++; $display("FAIL frm_s2_count got=%0d want=3", sym_count); end
        step();
        total += 2;
        if (am_run !== 1'b0) begin bad++; $display("FAIL frm_end_run got=%b want=0", am_run); end
        if (sym_count !== 16'd3) begin bad++; $display("FAIL frm_end_count got=%0d want=3", sym_count); end
    endtask

    task automatic test_reports();
        sym_valid = 1'b1; sym_sof = 1'b1; sym_data = 8'hA1;
        step();
        sym_sof = 1'b0; sym_data = 8'hA2;
        step();
        sym_data = 8'hA3;
        step();
        sym_valid = 1'b0;
        step();
        report = 4'b0100;
        step();
        total += 2;
        if (report_hit !== 1'b1) begin bad++; $display("FAIL rep_hit got=%b want=1", report_hit); end
        if (first_hit_idx !== 16'd2) begin bad++; $display("FAIL rep_idx got=%0d want=2", first_hit_idx); end
        report = 4'b1000;
        step();
        total += 2;
        if (report_hit !== 1'b1) begin bad++; $display("FAIL rep2_hit got=%b want=1", report_hit); end
        if (first_hit_idx !== 16'd2) begin bad++; $display("FAIL rep2_idx got=%0d want=2", first_hit_idx); end
        report = 4'h0;
        step();
        sym_valid = 1'b1; sym_sof = 1'b1; sym_data = 8'hB1;
        step();
        sym_valid = 1'b0; sym_sof = 1'b0;
        step();
        total += 4;
        if (am_reset !== 1'b1) begin bad++; $display("FAIL clr_reset got=%b want=1", am_reset); end
        if (report_hit !== 1'b0) begin bad++; $display("FAIL clr_hit got=%b want=0", report_hit); end
        if (first_hit_idx !== 16'd0) begin bad++; $display("FAIL clr_idx got=%0d want=0", first_hit_idx); end
        if (sym_count !== 16'd0) begin bad++; $display("FAIL clr_count got=%0d want=0", sym_count); end
        report = 4'hF;
        step();
        total += 4;
        if (am_run !== 1'b1) begin bad++; $display("FAIL clr_run got=%b want=1", am_run); end
        if (am_symbols !== 8'hB1) begin bad++; $display("FAIL clr_sym got=%h want=b1", am_symbols); end
        if (report_hit !== 1'b0) begin bad++; $display("FAIL clr_ignored_hit got=%b want=0", report_hit); end
        if (sym_count !== 16'd1) begin bad++; $display("FAIL clr_count1 got=%0d want=1", sym_count); end
        report = 4'h0;
        step();
    endtask

    task automatic test_back_to_back();
        int pushed = 0;
        int popped = 0;
        bit saw_full = 1'b0;
        sym_valid = 1'b1; sym_sof = 1'b1; sym_data = 8'hC0;
        for (int cyc = 0; cyc < 100 && popped < 8; cyc++) begin
            bit         will_push;
            logic       exp_rdy;
            logic [7:0] exp_sym;
            will_push = sym_valid && sym_ready;
            step();
            if (will_push) pushed++;
            if (am_run) begin
                exp_sym = 8'hC0 + 8'(popped);
                total++;
                if (am_symbols !== exp_sym) begin
                    bad++; $display("FAIL bp_order got=%h want=%h", am_symbols, exp_sym);
                end
                popped++;
            end
            exp_rdy = (pushed - popped) < int'(DEPTH);
            total++;
            if (sym_ready !== exp_rdy) begin
                bad++; $display("FAIL bp_ready got=%b want=%b", sym_ready, exp_rdy);
            end
            if (!sym_ready) saw_full = 1'b1;
            if (pushed < 8) begin
                sym_valid = 1'b1; sym_data = 8'hC0 + 8'(pushed);
            end else begin
                sym_valid = 1'b0;
            end
        end
        sym_valid = 1'b0; sym_sof = 1'b0;
        total += 2;
        if (popped != 8) begin bad++; $display("FAIL bp_drain got=%0d want=8", popped); end
        if (!saw_full) begin bad++; $display("FAIL bp_full_seen got=0 want=1"); end
        step();
    endtask

    task automatic test_abort();
        logic [CNT_W-1:0] cnt_before;
        sym_valid = 1'b1; sym_sof = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sym_data = 8'hD1 + 8'(i);
            step();
        end
        cnt_before = sym_count;
        total += 2;
        if (am_reset !== 1'b1) begin bad++; $display("FAIL ab_pre_reset got=%b want=1", am_reset); end
        if (sym_ready !== 1'b1) begin bad++; $display("FAIL ab_pre_ready got=%b want=1", sym_ready); end
        abort = 1'b1; sym_sof = 1'b0; sym_data = 8'h77;
        step();
        abort = 1'b0; sym_valid = 1'b0;
        total += 4;
        if (am_run !== 1'b0) begin bad++; $display("FAIL ab_run got=%b want=0", am_run); end
        if (am_reset !== 1'b0) begin bad++; $display("FAIL ab_reset got=%b want=0", am_reset); end
        if (sym_ready !== 1'b1) begin bad++; $display("FAIL ab_ready got=%b want=1", sym_ready); end
        if (sym_count !== cnt_before) begin
            bad++; $display("FAIL ab_count got=%0d want=%0d", sym_count, cnt_before);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            total++;
            if (am_run !== 1'b0) begin
                bad++; $display("FAIL ab_flushed got=run sym=%h want=idle", am_symbols);
            end
        end
    endtask

    task automatic test_random();
        logic [8:0]       exp_q[$];
        logic [8:0]       head;
        logic [CNT_W-1:0] mcount = '0;
        logic [CNT_W-1:0] midx = '0;
        logic             mhit = 1'b0;
        logic             prev_reset = 1'b1;
        logic             exp_rdy;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        for (int cyc = 0; cyc < 600; cyc++) begin
            bit will_push;
            sym_valid = ($urandom_range(0, 99) < 55);
            sym_sof   = ($urandom_range(0, 99) < 20);
            sym_data  = 8'($urandom);
            report    = ($urandom_range(0, 99) < 10) ? 4'($urandom) : 4'h0;
            abort     = ($urandom_range(0, 149) == 0);
            will_push = sym_valid && sym_ready && !abort;
            step();
            // Reports count only in cycles where the automaton was out of reset.
            if (!prev_reset && report != 4'h0) begin
                if (!mhit) midx = mcount;
                mhit = 1'b1;
            end
            if (am_reset && !prev_reset) begin
                total++;
                if (exp_q.size() == 0 || exp_q[0][8] !== 1'b1) begin
                    bad++; $display("FAIL rnd_frame got=reset want=sof_at_head cyc=%0d", cyc);
                end
                mhit = 1'b0; midx = '0; mcount = '0;
            end
            if (am_run) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL rnd_run got=run want=idle cyc=%0d", cyc);
                end else begin
                    head = exp_q.pop_front();
                    if (am_symbols !== head[7:0]) begin
                        bad++; $display("FAIL rnd_sym got=%h want=%h cyc=%0d", am_symbols, head[7:0], cyc);
                    end else if (head[8] && !prev_reset) begin
                        bad++; $display("FAIL rnd_unframed got=no_reset want=reset cyc=%0d", cyc);
                    end
                    if (head[8]) mcount = CNT_W'(1);
                    else if (mcount != {CNT_W{1'b1}}) mcount = mcount + CNT_W'(1);
                end
            end
            if (abort) exp_q.delete();
            else if (will_push) exp_q.push_back({sym_sof, sym_data});
            exp_rdy = (exp_q.size() < int'(DEPTH));
            total += 4;
            if (sym_count !== mcount) begin
                bad++; $display("FAIL rnd_count got=%0d want=%0d cyc=%0d", sym_count, mcount, cyc);
            end
            if (report_hit !== mhit) begin
                bad++; $display("FAIL rnd_hit got=%b want=%b cyc=%0d", report_hit, mhit, cyc);
            end
            if (first_hit_idx !== midx) begin
                bad++; $display("FAIL rnd_idx got=%0d want=%0d cyc=%0d", first_hit_idx, midx, cyc);
            end
            if (sym_ready !== exp_rdy) begin
                bad++; $display("FAIL rnd_ready got=%b want=%b cyc=%0d", sym_ready, exp_rdy, cyc);
            end
            prev_reset = am_reset;
        end
        sym_valid = 1'b0; abort = 1'b0; report = 4'h0; sym_sof = 1'b0;
    endtask

    task automatic test_async_reset();
        abort = 1'b1;
        step();
        abort = 1'b0;
        sym_valid = 1'b1; sym_sof = 1'b0; sym_data = 8'h31;
        step();
        sym_data = 8'h32;
        step();
        total++;
        if (am_run !== 1'b1 || am_symbols !== 8'h31) begin
            bad++; $display("FAIL ar_stream got=%b/%h want=1/31", am_run, am_symbols);
        end
        sym_data = 8'h33;
        step();
        sym_valid = 1'b0;
        #2;
        rst_ni = 1'b0;
        #1;
        total += 5;
        if (am_reset !== 1'b1) begin bad++; $display("FAIL ar_reset got=%b want=1", am_reset); end
        if (am_run !== 1'b0) begin bad++; $display("FAIL ar_run got=%b want=0", am_run); end
        if (sym_ready !== 1'b1) begin bad++; $display("FAIL ar_ready got=%b want=1", sym_ready); end
        if (sym_count !== '0) begin bad++; $display("FAIL ar_count got=%0d want=0", sym_count); end
        if (am_symbols !== 8'h00) begin bad++; $display("FAIL ar_sym got=%h want=00", am_symbols); end
        step();
        rst_ni = 1'b1;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_framing();
        test_reports();
        test_back_to_back();
        test_abort();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ltl_symbol_feeder.md
Name: ltl_symbol_feeder

Overview:
- Producer side of the monitor automaton symbol interface.
- Accepts 8-bit trace symbols from the core-side tracer over a valid/ready handshake and buffers them in a small FIFO.
- Drives run, reset and symbols to one automaton instance, including the one-cycle reset framing each new trace needs.
- Collects the automaton report lines into a sticky hit flag and records the symbol index of the first hit.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- NUM_REPORTS, 4, width of the automaton report bus.
- CNT_W, 16, width of the symbol counter and the first-hit index.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- sym_valid_i  in  1  a symbol is offered.
- sym_ready_o  out  1  FIFO can accept; equals !full.
- sym_data_i  in  8  symbol value.
- sym_sof_i  in  1  this symbol starts a new trace.
- abort_i  in  1  discards all buffered symbols.
- am_reset_o  out  1  automaton reset, active-high.
- am_run_o  out  1  automaton consumes am_symbols_o this cycle.
- am_symbols_o  out  8  symbol to the automaton.
- report_i  in  NUM_REPORTS  automaton report outputs.
- report_hit_o  out  1  sticky: any report since the last trace start.
- first_hit_idx_o  out  CNT_W  value of sym_count_o when report_hit_o first set.
- sym_count_o  out  CNT_W  symbols emitted since the last trace start; saturates at all-ones.

Behaviour:
- Clock and reset: clk_i is the only clock. rst_ni is asynchronous active-low.
- Reset values while rst_ni=0:
  - am_reset_o=1, am_run_o=0, am_symbols_o=0.
  - report_hit_o=0, first_hit_idx_o=0, sym_count_o=0.
  - FIFO empty, so sym_ready_o=1. FSM in RUN.
- Registering: all am_* outputs are registered.
- FIFO:
  - Each entry is 9 bits: {sof, data}.
  - Push happens when sym_valid_i && sym_ready_o.
  - Read and write pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
  - A pop and a push in the same cycle are both legal; occupancy is then unchanged.
  - Push-to-emit latency: a push at edge N into an empty FIFO is popped at edge N+1. am_run_o=1 and am_symbols_o=data are then visible during cycle N+1..N+2.
- FSM state RUN:
  - FIFO empty: am_run_o<=0, am_reset_o<=0, am_symbols_o holds its value.
  - Head sof=0: pop; am_symbols_o<=data, am_run_o<=1, am_reset_o<=0, sym_count_o increments (saturating).
  - Head sof=1: no pop; am_reset_o<=1, am_run_o<=0; clear report_hit_o, first_hit_idx_o and sym_count_o; go to START.
- FSM state START (exactly one cycle):
  - Pop the head.
  - am_reset_o<=0, am_run_o<=1, am_symbols_o<=head data, sym_count_o<=1.
  - Return to RUN.
  - Result: the reset falling edge and the first symbol appear on the same clock edge, so the automaton sees start_of_data together with the first symbol.
- After power-on: am_reset_o stays 1 until the first RUN cycle, then drops to 0. The first trace must still begin with sof=1 to get a framed start.
- Reports:
  - In any cycle with am_reset_o=0 and |report_i=1: report_hit_o<=1.
  - If report_hit_o was 0 in that cycle, also first_hit_idx_o<=sym_count_o.
  - Reports are ignored while am_reset_o=1.
- abort_i (highest priority):
  - Next edge: FIFO emptied, a push in the same cycle is discarded, am_run_o<=0, FSM<=RUN.
  - report_hit_o, first_hit_idx_o and sym_count_o hold.
  - abort_i during START cancels the pop; am_reset_o<=0.
- Back-pressure: sym_ready_o=0 while full, so no push can occur.
- Idle gaps: an empty FIFO mid-trace leaves am_run_o=0; the automaton state holds, and the next symbol continues the same trace.
- Reset mid-operation: asserting rst_ni=0 forces all reset values immediately, without waiting for a clock edge.

Test Plan:
- Release rst_ni; push {sof=1,0x05}, {0,0x88}, {0,0x10} back-to-back. Required: am_reset_o=1 for one cycle, then am_run_o=1 for three consecutive cycles with symbols 0x05, 0x88, 0x10; sym_count_o reaches 3.
- Hold sym_valid_i with the sink stalled by sof framing; push 5 symbols into DEPTH=4. Required: sym_ready_o=0 after 4 entries; no symbol lost; output order preserved.
- Drive report_i=4'b0100 during the cycle with sym_count_o=2. Required: report_hit_o=1 from the next cycle and first_hit_idx_o=2. A later report_i=4'b1000 leaves first_hit_idx_o=2.
- With a hit latched, push a new sof=1 symbol. Required: report_hit_o=0 and sym_count_o=0 during the reset cycle; a report_i pulse in that cycle is ignored.
- Fill 3 entries, then assert abort_i together with a push of 0x77. Required: FIFO empty, 0x77 never emitted, am_run_o=0 next cycle, sym_count_o unchanged.
- Drop rst_ni asynchronously mid-stream, between edges. Required: am_reset_o=1, am_run_o=0 and sym_ready_o=1 immediately, before the next edge.
